// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared cache FSM encodings and default geometry
//
// Purpose : FSM state encodings and default line geometry shared by the
//           instruction cache and the data cache.
// Ports   : none (package).

package icache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } cache_state_t;

    localparam int DEF_INDEX_BITS = 4;  // 16 lines
    localparam int DEF_WORD_BITS  = 2;  // 4 words (16 bytes) per line

    // Tag width left over from a 32-bit byte address once the byte offset,
    // word offset and index fields are removed.
    function automatic int tag_bits(input int index_bits, input int word_bits);
        return 30 - index_bits - word_bits;
    endfunction

endpackage

// File: rtl/icache_store.sv
// rtl/icache_store.sv - valid/tag/data arrays of the direct-mapped icache
//
// Purpose : Line storage for the instruction cache. One combinational read
//           port, one word write port, one line valid/tag write port and a
//           single-line invalidate port.
// Ports   : clk, rst       - clock, synchronous active-high reset (valid bits only)
//           rd_index/rd_word -> rd_valid, rd_tag, rd_data (combinational)
//           word_we, wr_index, wr_word, wr_data - write one data word
//           line_we, wr_index, line_tag          - write tag and set valid
//           inval_we, inval_index                - clear one valid bit

module icache_store
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int WORD_BITS  = DEF_WORD_BITS,
    parameter int TAG_BITS   = tag_bits(INDEX_BITS, WORD_BITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [WORD_BITS-1:0]  rd_word,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  word_we,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [WORD_BITS-1:0]  wr_word,
    input  logic [31:0]           wr_data,
    input  logic                  line_we,
    input  logic [TAG_BITS-1:0]   line_tag,
    input  logic                  inval_we,
    input  logic [INDEX_BITS-1:0] inval_index
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << (INDEX_BITS + WORD_BITS);

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [WORDS];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[{rd_index, rd_word}];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (line_we) begin
            valid_q[wr_index] <= 1'b1;
        end else if (inval_we) begin
            valid_q[inval_index] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[wr_index] <= line_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (word_we) begin
            data_q[{wr_index, wr_word}] <= wr_data;
        end
    end

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache with line refill
//
// Purpose : Answers fetch requests by PC with a one-cycle response pulse;
//           on a miss refills the whole line word by word from memory.
// Ports   : clk, rst, rdy (global enable), clear (pipeline flush)
//           fetch_ready_in, fetch_pc          - fetch request
//           instcache_ready_out, inst_out     - fetch response
//           icache_mem_req, icache_mem_addr   - word read request to memory
//           mem_icache_data, mem_icache_ready - memory read data

module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int WORD_BITS  = DEF_WORD_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        fetch_ready_in,
    input  logic [31:0] fetch_pc,
    output logic        instcache_ready_out,
    output logic [31:0] inst_out,
    output logic        icache_mem_req,
    output logic [31:0] icache_mem_addr,
    input  logic [31:0] mem_icache_data,
    input  logic        mem_icache_ready
);

    localparam int TAG_BITS  = tag_bits(INDEX_BITS, WORD_BITS);
    localparam int LINE_BITS = TAG_BITS + INDEX_BITS;

    cache_state_t          state_q, state_d;
    logic [WORD_BITS-1:0]  counter_q, counter_d;
    logic [LINE_BITS-1:0]  base_q, base_d;   // {tag, index} of the line being refilled
    logic                  req_d;
    logic                  ready_d;
    logic [31:0]           inst_d;

    logic                  wr_en;
    logic                  word_we, line_we, inval_we;
    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [31:0]           rd_data;
    logic                  hit;
    logic                  unused_pc_bits;

    assign unused_pc_bits = ^fetch_pc[1:0];

    // Store writes only happen on cycles where state is allowed to advance.
    assign wr_en = rdy && !rst;

    // The refill address is rebuilt from the latched line and the word
    // counter, so it advances the cycle after each accepted word and is
    // naturally frozen while rdy is low.
    assign icache_mem_addr = {base_q, counter_q, 2'b00};

    icache_store #(
        .INDEX_BITS(INDEX_BITS),
        .WORD_BITS (WORD_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (fetch_pc[WORD_BITS+INDEX_BITS+1:WORD_BITS+2]),
        .rd_word    (fetch_pc[WORD_BITS+1:2]),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .word_we    (word_we),
        .wr_index   (base_q[INDEX_BITS-1:0]),
        .wr_word    (counter_q),
        .wr_data    (mem_icache_data),
        .line_we    (line_we),
        .line_tag   (base_q[LINE_BITS-1:INDEX_BITS]),
        .inval_we   (inval_we),
        .inval_index(fetch_pc[WORD_BITS+INDEX_BITS+1:WORD_BITS+2])
    );

    assign hit = rd_valid && (rd_tag == fetch_pc[31:WORD_BITS+INDEX_BITS+2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= IDLE;
            counter_q           <= '0;
            base_q              <= '0;
            icache_mem_req      <= 1'b0;
            instcache_ready_out <= 1'b0;
            inst_out            <= '0;
        end else if (rdy) begin
            state_q             <= state_d;
            counter_q           <= counter_d;
            base_q              <= base_d;
            icache_mem_req      <= req_d;
            instcache_ready_out <= ready_d;
            inst_out            <= inst_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        base_d    = base_q;
        req_d     = icache_mem_req;
        ready_d   = 1'b0;
        inst_d    = inst_out;
        word_we   = 1'b0;
        line_we   = 1'b0;
        inval_we  = 1'b0;

        if (clear) begin
            // Flush wins over everything; a partially refilled line keeps
            // the valid bit that was cleared when its refill started.
            state_d   = IDLE;
            counter_d = '0;
            req_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A request still visible in the response cycle belongs
                    // to the request just answered, so it is not looked up.
                    if (fetch_ready_in && !instcache_ready_out) begin
                        if (hit) begin
                            ready_d = 1'b1;
                            inst_d  = rd_data;
                        end else begin
                            inval_we  = wr_en;
                            base_d    = fetch_pc[31:WORD_BITS+2];
                            counter_d = '0;
                            req_d     = 1'b1;
                            state_d   = REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (mem_icache_ready) begin
                        word_we   = wr_en;
                        counter_d = counter_q + 1'b1;
                        if (&counter_q) begin
                            line_we = wr_en;
                            req_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache

module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        fetch_ready_in;
    logic [31:0] fetch_pc;
    logic        instcache_ready_out;
    logic [31:0] inst_out;
    logic        icache_mem_req;
    logic [31:0] icache_mem_addr;
    logic [31:0] mem_icache_data;
    logic        mem_icache_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    icache dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .clear              (clear),
        .fetch_ready_in     (fetch_ready_in),
        .fetch_pc           (fetch_pc),
        .instcache_ready_out(instcache_ready_out),
        .inst_out           (inst_out),
        .icache_mem_req     (icache_mem_req),
        .icache_mem_addr    (icache_mem_addr),
        .mem_icache_data    (mem_icache_data),
        .mem_icache_ready   (mem_icache_ready)
    );

    // Memory side of a full line refill. Entered at the negedge after the
    // miss edge; returns at the negedge after the last word was accepted.
    task automatic serve_line(input logic [31:0] base, input logic [31:0] d0, input string name);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (icache_mem_req !== 1'b1 || icache_mem_addr !== base + 32'(4 * i) || instcache_ready_out !== 1'b0) begin
                errors++;
                $display("FAIL %s word%0d: req=%b addr=%h ready=%b, required req=1 addr=%h ready=0",
                         name, i, icache_mem_req, icache_mem_addr, instcache_ready_out, base + 32'(4 * i));
            end
            mem_icache_ready = 1'b1;
            mem_icache_data  = d0 + 32'(i);
            @(negedge clk);
        end
        mem_icache_ready = 1'b0;
        mem_icache_data  = '0;
    endtask

    // Refill done: req low now, response one cycle later, then a single pulse.
    task automatic finish_miss(input logic [31:0] exp, input string name);
        checks++;
        if (icache_mem_req !== 1'b0 || instcache_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL %s_relookup: req=%b ready=%b, required 0 0", name, icache_mem_req, instcache_ready_out);
        end
        @(negedge clk);
        checks++;
        if (instcache_ready_out !== 1'b1 || inst_out !== exp) begin
            errors++;
            $display("FAIL %s_resp: ready=%b inst=%h, required 1 %h", name, instcache_ready_out, inst_out, exp);
        end
        fetch_ready_in = 1'b0;
        @(negedge clk);
        checks++;
        if (instcache_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: ready=%b, required 0", name, instcache_ready_out);
        end
    endtask

    task automatic request(input logic [31:0] pc);
        fetch_pc       = pc;
        fetch_ready_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (instcache_ready_out !== 1'b0 || inst_out !== 32'h0 || icache_mem_req !== 1'b0 || icache_mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset: ready=%b inst=%h req=%b addr=%h, required all zero",
                     instcache_ready_out, inst_out, icache_mem_req, icache_mem_addr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cold_miss;
        request(32'h1004);
        serve_line(32'h1000, 32'hA0, "cold");
        finish_miss(32'hA1, "cold");
    endtask

    task automatic test_hit;
        request(32'h100C);
        checks++;
        if (instcache_ready_out !== 1'b1 || inst_out !== 32'hA3 || icache_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL hit: ready=%b inst=%h req=%b, required 1 000000a3 0", instcache_ready_out, inst_out, icache_mem_req);
        end
        fetch_ready_in = 1'b0;
        @(negedge clk);
        checks++;
        if (instcache_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL hit_pulse: ready=%b, required 0", instcache_ready_out);
        end
    endtask

    task automatic test_back_to_back;
        request(32'h1000);
        checks++;
        if (instcache_ready_out !== 1'b1 || inst_out !== 32'hA0) begin
            errors++;
            $display("FAIL b2b_first: ready=%b inst=%h, required 1 000000a0", instcache_ready_out, inst_out);
        end
        fetch_pc = 32'h1008;
        @(negedge clk);
        checks++;
        if (instcache_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: ready=%b, required 0", instcache_ready_out);
        end
        @(negedge clk);
        checks++;
        if (instcache_ready_out !== 1'b1 || inst_out !== 32'hA2) begin
            errors++;
            $display("FAIL b2b_second: ready=%b inst=%h, required 1 000000a2", instcache_ready_out, inst_out);
        end
        fetch_ready_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_conflict;
        request(32'h1104);
        serve_line(32'h1100, 32'hB0, "conflict_a");
        finish_miss(32'hB1, "conflict_a");
        request(32'h1004);
        serve_line(32'h1000, 32'hA0, "conflict_b");
        finish_miss(32'hA1, "conflict_b");
    endtask

    task automatic test_clear_mid_refill;
        request(32'h1104);
        for (int i = 0; i < 2; i++) begin
            mem_icache_ready = 1'b1;
            mem_icache_data  = 32'hB0 + 32'(i);
            @(negedge clk);
        end
        mem_icache_ready = 1'b0;
        clear            = 1'b1;
        fetch_ready_in   = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        checks++;
        if (icache_mem_req !== 1'b0 || instcache_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL clear_refill: req=%b ready=%b, required 0 0", icache_mem_req, instcache_ready_out);
        end
        @(negedge clk);
        checks++;
        if (icache_mem_req !== 1'b0 || instcache_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL clear_idle: req=%b ready=%b, required 0 0", icache_mem_req, instcache_ready_out);
        end
        request(32'h1104);
        serve_line(32'h1100, 32'hB0, "clear_rerefill");
        finish_miss(32'hB1, "clear_rerefill");
    endtask

    task automatic test_clear_priority;
        // clear together with a hitting request: no response, line survives
        fetch_pc       = 32'h1108;
        fetch_ready_in = 1'b1;
        clear          = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++;
        if (instcache_ready_out !== 1'b0 || icache_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL clear_hit: ready=%b req=%b, required 0 0", instcache_ready_out, icache_mem_req);
        end
        @(negedge clk);
        checks++;
        if (instcache_ready_out !== 1'b1 || inst_out !== 32'hB2) begin
            errors++;
            $display("FAIL clear_keep: ready=%b inst=%h, required 1 000000b2", instcache_ready_out, inst_out);
        end
        fetch_ready_in = 1'b0;
        @(negedge clk);

        // clear together with the last memory word: line must stay invalid
        request(32'h2004);
        for (int i = 0; i < 3; i++) begin
            mem_icache_ready = 1'b1;
            mem_icache_data  = 32'hC0 + 32'(i);
            @(negedge clk);
        end
        mem_icache_data = 32'hC3;
        clear           = 1'b1;
        fetch_ready_in  = 1'b0;
        @(negedge clk);
        clear            = 1'b0;
        mem_icache_ready = 1'b0;
        checks++;
        if (icache_mem_req !== 1'b0 || instcache_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL clear_mem: req=%b ready=%b, required 0 0", icache_mem_req, instcache_ready_out);
        end
        request(32'h2004);
        checks++;
        if (icache_mem_req !== 1'b1 || instcache_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL clear_mem_invalid: req=%b ready=%b, required 1 0", icache_mem_req, instcache_ready_out);
        end
        serve_line(32'h2000, 32'hD0, "clear_mem_refill");
        finish_miss(32'hD1, "clear_mem_refill");
    endtask

    task automatic test_rdy_stall;
        request(32'h3008);
        checks++;
        if (icache_mem_addr !== 32'h3000 || icache_mem_req !== 1'b1) begin
            errors++;
            $display("FAIL stall_w0: addr=%h req=%b, required 00003000 1", icache_mem_addr, icache_mem_req);
        end
        mem_icache_ready = 1'b1;
        mem_icache_data  = 32'hE0;
        @(negedge clk);
        rdy             = 1'b0;
        mem_icache_data = 32'hE1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (icache_mem_addr !== 32'h3004 || icache_mem_req !== 1'b1 || instcache_ready_out !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: addr=%h req=%b ready=%b, required 00003004 1 0",
                         i, icache_mem_addr, icache_mem_req, instcache_ready_out);
            end
        end
        rdy = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (icache_mem_addr !== 32'h3000 + 32'(4 * i) || icache_mem_req !== 1'b1) begin
                errors++;
                $display("FAIL stall_w%0d: addr=%h req=%b, required %h 1",
                         i, icache_mem_addr, icache_mem_req, 32'h3000 + 32'(4 * i));
            end
            mem_icache_data = 32'hE0 + 32'(i);
            @(negedge clk);
        end
        mem_icache_ready = 1'b0;
        finish_miss(32'hE2, "stall");
    endtask

    initial begin
        rst              = 1'b1;
        rdy              = 1'b1;
        clear            = 1'b0;
        fetch_ready_in   = 1'b0;
        fetch_pc         = '0;
        mem_icache_data  = '0;
        mem_icache_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_cold_miss();
        test_hit();
        test_back_to_back();
        test_conflict();
        test_clear_mid_refill();
        test_clear_priority();
        test_rdy_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
